multicycle_controller: RTL

- Parametrised control unit for the multi-cycle RV32I core.
- Sequences each instruction through an FSM over a shared ALU and a unified instruction/data memory.
- Emits per-cycle datapath selects and ALU operation, and waits on a memory-ready handshake.
- Flags illegal opcodes (halt) and maintains a retired-instruction counter. Sits between the instruction register fields and the multi-cycle datapath.

---
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences each instruction over the
// shared ALU and unified memory, emits datapath selects, and counts retirements.
module multicycle_controller #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int RET_CNT_W     = 32,
   parameter bit SUPPORT_BNE   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 adr_src,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic [1:0]           result_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           imm_src,
   output logic                 reg_write,
   output logic [3:0]           alu_control,
   output logic                 illegal_instr,
   output logic                 instr_retired,
   output logic [RET_CNT_W-1:0] retired_count
);

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_EXECU, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
      S_JALR2, S_TRAP
   } state_t;

   state_t state;
   logic   jalr_link;   // JAL state entered from JALR2: link only, no PC write
   logic   mr;

   assign mr = MEM_HANDSHAKE ? mem_ready : 1'b1;

   function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
      logic [3:0] r;
      r = ALU_ADD;
      case (f3)
         3'b000: r = alt ? ALU_SUB : ALU_ADD;
         3'b001: r = ALU_SLL;
         3'b010: r = ALU_SLT;
         3'b011: r = ALU_SLTU;
         3'b100: r = ALU_XOR;
         3'b101: r = alt ? ALU_SRA : ALU_SRL;
         3'b110: r = ALU_OR;
         3'b111: r = ALU_AND;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_FETCH;
         jalr_link     <= 1'b0;
         retired_count <= '0;
      end else begin
         if (instr_retired)
            retired_count <= retired_count + RET_CNT_W'(1);
         case (state)
            S_FETCH:  if (mr) state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW:      state <= S_MEMADR;
                  OP_R:              state <= S_EXECR;
                  OP_I:              state <= S_EXECI;
                  OP_BR:             state <= S_BRANCH;
                  OP_JAL:            state <= S_JAL;
                  OP_JALR:           state <= S_JALR;
                  OP_LUI, OP_AUIPC:  state <= S_EXECU;
                  default:           state <= S_TRAP;
               endcase
            end
            S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mr) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWRITE: if (mr) state <= S_FETCH;
            S_EXECR, S_EXECI, S_EXECU: state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BRANCH:   state <= S_FETCH;
            S_JAL: begin
               state     <= S_ALUWB;
               jalr_link <= 1'b0;
            end
            S_JALR:     state <= S_JALR2;
            S_JALR2: begin
               state     <= S_JAL;
               jalr_link <= 1'b1;
            end
            S_TRAP:     state <= S_TRAP;
            default:    state <= S_TRAP;
         endcase
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      imm_src       = 3'b000;
      reg_write     = 1'b0;
      alu_control   = ALU_ADD;
      illegal_instr = 1'b0;
      instr_retired = 1'b0;
      case (state)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mr;
            pc_write   = mr;
         end
         S_DECODE: begin
            // branch target is precomputed here so BRANCH only needs the compare
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 3'b010;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = (op == OP_LW) ? 3'b000 : 3'b001;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src       = 1'b1;
            mem_write     = 1'b1;
            instr_retired = mr;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_dec(funct3, funct7b5);
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_dec(funct3, (funct3 != 3'b000) && funct7b5);
         end
         S_EXECU: begin
            alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 3'b100;
         end
         S_ALUWB: begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         S_BRANCH: begin
            // unsupported branch kinds fall through as a not-taken NOP
            alu_src_a     = 2'b10;
            alu_control   = ALU_SUB;
            instr_retired = 1'b1;
            case (funct3)
               3'b000:  pc_write = zero;
               3'b001:  pc_write = SUPPORT_BNE && !zero;
               default: pc_write = 1'b0;
            endcase
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = !jalr_link;
         end
         S_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_JALR2:  pc_write = 1'b1;
         S_TRAP:   illegal_instr = 1'b1;
         default:  illegal_instr = 1'b1;
      endcase
   end

endmodule
